// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer: width default, op codes, FSM states.
package alu_seq_ctrl_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_MUL = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL_ADD,
        S_MUL_SHIFT,
        S_DIV_SHIFT,
        S_DIV_SUB,
        S_DONE
    } state_t;

    // True when the op code selects a supported operation.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_regs.sv
// AH/AL/BREG operand registers plus the extension bit, with load and shift controls.
module alu_seq_regs #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         i_load,
    input  logic [N-1:0] i_ah_ld,
    input  logic [N-1:0] i_al_ld,
    input  logic [N-1:0] i_breg_ld,
    input  logic         i_shl,
    input  logic         i_shr,
    input  logic         i_ah_we,
    input  logic [N-1:0] i_ah_d,
    input  logic         i_ext_we,
    input  logic         i_ext_d,
    input  logic         i_q_set,
    output logic [N-1:0] o_ah,
    output logic [N-1:0] o_al,
    output logic [N-1:0] o_breg,
    output logic         o_ext
);

    logic [N-1:0] r_ah;
    logic [N-1:0] r_al;
    logic [N-1:0] r_breg;
    logic         r_ext;

    // Load has priority over shifts; single-field writes apply only when not shifting.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ah   <= '0;
            r_al   <= '0;
            r_breg <= '0;
            r_ext  <= 1'b0;
        end else if (i_load) begin
            r_ah   <= i_ah_ld;
            r_al   <= i_al_ld;
            r_breg <= i_breg_ld;
            r_ext  <= 1'b0;
        end else if (i_shl) begin
            {r_ext, r_ah, r_al} <= {r_ah, r_al, 1'b0};
        end else if (i_shr) begin
            {r_ext, r_ah, r_al} <= {1'b0, r_ext, r_ah, r_al[N-1:1]};
        end else begin
            if (i_ah_we)  r_ah   <= i_ah_d;
            if (i_ext_we) r_ext  <= i_ext_d;
            if (i_q_set)  r_al[0] <= 1'b1;
        end
    end

    assign o_ah   = r_ah;
    assign o_al   = r_al;
    assign o_breg = r_breg;
    assign o_ext  = r_ext;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving the external ALU: single-cycle ADD/SUB/AND,
// shift-add multiply and restoring divide over the AH/AL/BREG registers.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    a_in,
    input  logic [N-1:0]    b_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [N-1:0]    res_hi,
    output logic [N-1:0]    res_lo,
    output logic [N-1:0]    ah_out,
    output logic [N-1:0]    breg_out,
    output logic            alu_add,
    output logic            alu_sub,
    output logic            alu_and,
    output logic            alu_mul,
    output logic            alu_div,
    output logic            al_lsb,
    input  logic [N-1:0]    alu_res,
    input  logic            fa_cout
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;
    logic [CNT_W-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [N-1:0]    r_res_hi;
    logic [N-1:0]    r_res_lo;

    logic [N-1:0]    w_ah;
    logic [N-1:0]    w_al;
    logic [N-1:0]    w_breg;
    logic            w_ext;
    logic [N-1:0]    w_ah_shr;
    logic [N-1:0]    w_al_shr;

    logic            w_load;
    logic [N-1:0]    w_ah_ld;
    logic [N-1:0]    w_al_ld;
    logic [N-1:0]    w_breg_ld;
    logic            w_shl;
    logic            w_shr;
    logic            w_ah_we;
    logic            w_ext_we;
    logic            w_ext_d;
    logic            w_q_set;
    logic            w_op_we;
    logic            w_cnt_ld;
    logic            w_cnt_dec;
    logic            w_res_we;
    logic [N-1:0]    w_res_hi_d;
    logic [N-1:0]    w_res_lo_d;
    logic            w_err_we;
    logic            w_err_d;
    logic            w_hi_bit;
    logic            w_sub_ok;

    alu_seq_regs #(.N(N)) u_regs (
        .clk       (clk),
        .clr       (clr),
        .i_load    (w_load),
        .i_ah_ld   (w_ah_ld),
        .i_al_ld   (w_al_ld),
        .i_breg_ld (w_breg_ld),
        .i_shl     (w_shl),
        .i_shr     (w_shr),
        .i_ah_we   (w_ah_we),
        .i_ah_d    (alu_res),
        .i_ext_we  (w_ext_we),
        .i_ext_d   (w_ext_d),
        .i_q_set   (w_q_set),
        .o_ah      (w_ah),
        .o_al      (w_al),
        .o_breg    (w_breg),
        .o_ext     (w_ext)
    );

    // Post-shift view of {ext,AH,AL} so the final multiply step can publish it directly.
    assign w_ah_shr = {w_ext, w_ah[N-1:1]};
    assign w_al_shr = {w_ah[0], w_al[N-1:1]};
    // Subtract succeeds when the shifted-out bit is set or the ALU reports no borrow.
    assign w_sub_ok = w_ext | fa_cout;

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state, ALU control decode and datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_ah_ld    = '0;
        w_al_ld    = '0;
        w_breg_ld  = b_in;
        w_shl      = 1'b0;
        w_shr      = 1'b0;
        w_ah_we    = 1'b0;
        w_ext_we   = 1'b0;
        w_ext_d    = 1'b0;
        w_q_set    = 1'b0;
        w_op_we    = 1'b0;
        w_cnt_ld   = 1'b0;
        w_cnt_dec  = 1'b0;
        w_res_we   = 1'b0;
        w_res_hi_d = '0;
        w_res_lo_d = '0;
        w_err_we   = 1'b0;
        w_err_d    = 1'b0;
        w_hi_bit   = 1'b0;
        alu_add    = 1'b0;
        alu_sub    = 1'b0;
        alu_and    = 1'b0;
        alu_mul    = 1'b0;
        alu_div    = 1'b0;
        al_lsb     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_we  = 1'b1;
                    w_cnt_ld = 1'b1;
                    w_err_we = 1'b1;
                    if (!op_legal(op)) begin
                        w_err_d = 1'b1;
                        w_next  = S_DONE;
                    end else if ((op == OP_DIV) && (b_in == '0)) begin
                        w_err_d    = 1'b1;
                        w_res_we   = 1'b1;
                        w_res_hi_d = a_in;
                        w_res_lo_d = '1;
                        w_next     = S_DONE;
                    end else if ((op == OP_MUL) || (op == OP_DIV)) begin
                        w_load  = 1'b1;
                        w_al_ld = a_in;
                        w_next  = (op == OP_MUL) ? S_MUL_ADD : S_DIV_SHIFT;
                    end else begin
                        w_load  = 1'b1;
                        w_ah_ld = a_in;
                        w_next  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADD: begin
                        alu_add  = 1'b1;
                        w_hi_bit = fa_cout;
                    end
                    OP_SUB: begin
                        alu_sub  = 1'b1;
                        w_hi_bit = !fa_cout;
                    end
                    default: begin
                        alu_and  = 1'b1;
                    end
                endcase
                w_res_we   = 1'b1;
                w_res_lo_d = alu_res;
                w_res_hi_d = N'(w_hi_bit);
                w_next     = S_DONE;
            end
            S_MUL_ADD: begin
                alu_mul  = 1'b1;
                al_lsb   = w_al[0];
                w_ext_we = 1'b1;
                w_ext_d  = w_al[0] & fa_cout;
                w_ah_we  = w_al[0];
                w_next   = S_MUL_SHIFT;
            end
            S_MUL_SHIFT: begin
                w_shr     = 1'b1;
                w_cnt_dec = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_res_we   = 1'b1;
                    w_res_hi_d = w_ah_shr;
                    w_res_lo_d = w_al_shr;
                    w_next     = S_DONE;
                end else begin
                    w_next     = S_MUL_ADD;
                end
            end
            S_DIV_SHIFT: begin
                w_shl  = 1'b1;
                w_next = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                alu_div   = 1'b1;
                w_ah_we   = w_sub_ok;
                w_q_set   = w_sub_ok;
                w_cnt_dec = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_res_we   = 1'b1;
                    w_res_hi_d = w_sub_ok ? alu_res : w_ah;
                    w_res_lo_d = w_sub_ok ? {w_al[N-1:1], 1'b1} : w_al;
                    w_next     = S_DONE;
                end else begin
                    w_next     = S_DIV_SHIFT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command, counter and registered status/result outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            if (w_op_we)        r_op  <= op;
            if (w_cnt_ld)       r_cnt <= CNT_INIT;
            else if (w_cnt_dec) r_cnt <= r_cnt - CNT_LAST;
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            if (w_err_we) r_err <= w_err_d;
            if (w_res_we) begin
                r_res_hi <= w_res_hi_d;
                r_res_lo <= w_res_lo_d;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign res_hi   = r_res_hi;
    assign res_lo   = r_res_lo;
    assign ah_out   = w_ah;
    assign breg_out = w_breg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the 4-bit ALU.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int unsigned N = 4;

    logic         clk;
    logic         clr;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] res_hi;
    logic [N-1:0] res_lo;
    logic [N-1:0] ah_out;
    logic [N-1:0] breg_out;
    logic         alu_add;
    logic         alu_sub;
    logic         alu_and;
    logic         alu_mul;
    logic         alu_div;
    logic         al_lsb;
    logic [N-1:0] alu_res;
    logic         fa_cout;

    int n_checks = 0;
    int n_err    = 0;

    alu_seq_ctrl #(.N(N)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .ah_out   (ah_out),
        .breg_out (breg_out),
        .alu_add  (alu_add),
        .alu_sub  (alu_sub),
        .alu_and  (alu_and),
        .alu_mul  (alu_mul),
        .alu_div  (alu_div),
        .al_lsb   (al_lsb),
        .alu_res  (alu_res),
        .fa_cout  (fa_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: subtract for SUB/DIV (carry=1 means no borrow), AND, else add.
    always_comb begin
        if (alu_sub || alu_div)
            {fa_cout, alu_res} = {1'b0, ah_out} + {1'b0, ~breg_out} + 5'd1;
        else if (alu_and) begin
            alu_res = ah_out & breg_out;
            fa_cout = 1'b0;
        end else
            {fa_cout, alu_res} = {1'b0, ah_out} + {1'b0, breg_out};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and wait (bounded) for done; optionally pulse start again at inj_cyc.
    task automatic run(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input int inj_cyc, output int lat, output int add_first, output int add_cnt);
        @(negedge clk);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; add_first = -1; add_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (alu_add) begin
                add_cnt++;
                if (add_first < 0) add_first = c;
            end
            if (c == inj_cyc) begin
                start = 1'b1; op = OP_ADD; a_in = 4'd1; b_in = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    int lat, af, ac;

    initial begin
        clr = 1'b1; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_res", {24'd0, res_hi, res_lo}, 32'h00);
        chk("rst_ctrl", {26'd0, alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb}, 32'd0);
        chk("rst_regs", {24'd0, ah_out, breg_out}, 32'h00);
        clr = 1'b0;

        // ADD 9+8 = 17
        run(OP_ADD, 4'd9, 4'd8, 0, lat, af, ac);
        chk("add_lat", lat, 2);
        chk("add_res", {24'd0, res_hi, res_lo}, 32'h11);
        chk("add_err", {31'd0, err}, 32'd0);
        chk("add_ctl_first", af, 1);
        chk("add_ctl_count", ac, 1);

        // SUB 3-5 borrows
        run(OP_SUB, 4'd3, 4'd5, 0, lat, af, ac);
        chk("sub_lat", lat, 2);
        chk("sub_res", {24'd0, res_hi, res_lo}, 32'h1E);

        // AND 12&10
        run(OP_AND, 4'd12, 4'd10, 0, lat, af, ac);
        chk("and_res", {24'd0, res_hi, res_lo}, 32'h08);

        // MUL 15*15 = 225
        run(OP_MUL, 4'd15, 4'd15, 0, lat, af, ac);
        chk("mul_lat", lat, 9);
        chk("mul_res", {24'd0, res_hi, res_lo}, 32'hE1);

        // MUL 6*0
        run(OP_MUL, 4'd6, 4'd0, 0, lat, af, ac);
        chk("mul0_res", {24'd0, res_hi, res_lo}, 32'h00);

        // MUL 7*9 = 63
        run(OP_MUL, 4'd7, 4'd9, 0, lat, af, ac);
        chk("mul79_res", {24'd0, res_hi, res_lo}, 32'h3F);

        // DIV 13/3 = 4 r 1
        run(OP_DIV, 4'd13, 4'd3, 0, lat, af, ac);
        chk("div_lat", lat, 9);
        chk("div_res", {24'd0, res_hi, res_lo}, 32'h14);
        chk("div_err", {31'd0, err}, 32'd0);

        // DIV 15/1
        run(OP_DIV, 4'd15, 4'd1, 0, lat, af, ac);
        chk("div1_res", {24'd0, res_hi, res_lo}, 32'h0F);

        // DIV 14/5 = 2 r 4
        run(OP_DIV, 4'd14, 4'd5, 0, lat, af, ac);
        chk("div145_res", {24'd0, res_hi, res_lo}, 32'h42);

        // Divide by zero
        run(OP_DIV, 4'd7, 4'd0, 0, lat, af, ac);
        chk("dz_lat", lat, 1);
        chk("dz_err", {31'd0, err}, 32'd1);
        chk("dz_res", {24'd0, res_hi, res_lo}, 32'h7F);

        // Illegal op keeps result, sets err
        run(3'b111, 4'd2, 4'd2, 0, lat, af, ac);
        chk("ill_lat", lat, 1);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_res", {24'd0, res_hi, res_lo}, 32'h7F);

        // Next accepted command clears err
        run(OP_ADD, 4'd2, 4'd3, 0, lat, af, ac);
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("add23_res", {24'd0, res_hi, res_lo}, 32'h05);

        // MUL 13*11 = 143 with a stray start in cycle 3
        run(OP_MUL, 4'd13, 4'd11, 3, lat, af, ac);
        chk("mulinj_lat", lat, 9);
        chk("mulinj_res", {24'd0, res_hi, res_lo}, 32'h8F);
        chk("mulinj_add", ac, 0);

        // DIV aborted by clr in cycle 4
        @(negedge clk);
        op = OP_DIV; a_in = 4'd9; b_in = 4'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("abort_nodone", {31'd0, done}, 32'd0);
        end
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res", {24'd0, res_hi, res_lo}, 32'h00);
        chk("abort_err", {31'd0, err}, 32'd0);
        chk("abort_ctrl", {26'd0, alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", {31'd0, done}, 32'd0);
        end
        clr = 1'b0;

        run(OP_ADD, 4'd4, 4'd5, 0, lat, af, ac);
        chk("post_lat", lat, 2);
        chk("post_res", {24'd0, res_hi, res_lo}, 32'h09);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
